ibex_sram_bridge: RTL
=====================

# ibex_sram_bridge

Bridge between one Ibex core memory port (instruction or data, request/grant/rvalid protocol) and the downstream single-clock `sram` block's split read/write ports. It:
- decodes the address window;
- issues read and write commands;
- holds write address and data for the `sram` commit cycle;
- returns a response per granted request, with error responses for out-of-window addresses.

One instance sits in front of each `sram` in the Ibex platform.

## Interface
- `BASE_ADDR`, default `32'h0000_0000`: byte base address of the window; aligned to the window size.
- `MEM_ADDR_WIDTH`, default 16: `sram` word-index width. Window is `4 << MEM_ADDR_WIDTH` bytes.

Ports:
- `CLK`, in, 1: clock.
- `RSTn`, in, 1: reset, synchronous, active-low; clock `CLK`.
- `req_i`, in, 1: core request.
- `we_i`, in, 1: 1 = write.
- `be_i`, in, 4: byte enables.
- `addr_i`, in, 32: byte address.
- `wdata_i`, in, 32: write data.
- `gnt_o`, out, 1: request accepted this cycle.
- `rvalid_o`, out, 1: response valid (reads and writes).
- `rdata_o`, out, 32: read data; 0 when not a valid read response.
- `err_o`, out, 1: response is an error; qualified by `rvalid_o`.
- `sram_read_addr_o`, out, `MEM_ADDR_WIDTH`: to `READ_ADDR`.
- `sram_oe_o`, out, 1: to `OE`.
- `sram_data_out_i`, in, 32: from `DATA_OUT`.
- `sram_data_valid_i`, in, 1: from `DATA_VALID`.
- `sram_write_addr_o`, out, `MEM_ADDR_WIDTH`: to `WRITE_ADDR`.
- `sram_data_in_o`, out, 32: to `DATA_IN`.
- `sram_be_o`, out, 4: to `BE`.
- `sram_we_o`, out, 1: to `WE`.
- `sram_wack_i`, in, 1: from `WACK`.
- `protocol_err_o`, out, 1: sticky; `sram` handshake mismatch seen.

## Operation
- Word index = `addr_i[MEM_ADDR_WIDTH+1:2]`.
- In-window means `addr_i[31:MEM_ADDR_WIDTH+2] == BASE_ADDR[31:MEM_ADDR_WIDTH+2]`.
- FSM has two states, IDLE and WHOLD.
  - IDLE: `gnt_o = req_i`.
  - WHOLD: `gnt_o = 0`.
  - While `RSTn = 0`: `gnt_o = 0`.
- Granted in-window read: `sram_oe_o = 1` and `sram_read_addr_o` = index, combinationally in the grant cycle. Sets the `rd_pend` flag. Stays in IDLE.
- Granted in-window write:
  - Grant cycle: `sram_we_o = 1`; `sram_be_o = be_i`; write address and data driven from the inputs.
  - The index and `wdata_i` are captured into hold registers. Go to WHOLD.
- WHOLD lasts exactly one cycle.
  - `sram_write_addr_o` and `sram_data_in_o` come from the hold registers; `sram_we_o = 0`; `sram_be_o = 0`.
  - The `sram` commits at the end of this cycle. Return to IDLE.
- Granted out-of-window request: no `sram` strobe. Sets `err_pend`.
- Responses, one cycle after grant:
  - In-window read: `rvalid_o = 1`, `rdata_o = sram_data_out_i`.
  - Write: `rvalid_o = 1` during WHOLD, `rdata_o = 0`.
  - Error: `rvalid_o = 1`, `err_o = 1`, `rdata_o = 0`.
- A write with `be_i = 0` is a normal write. It produces the normal response, and no memory byte changes.
- `protocol_err_o` sets and holds until reset on either of:
  - a read response cycle with `sram_data_valid_i = 0`;
  - a WHOLD cycle with nonzero latched BE and `sram_wack_i = 0`.
- Reset:
  - Reset clears state, pending flags and `protocol_err_o`.
  - The hold registers are **not** reset. A write already strobed completes at its correct address even when reset arrives during WHOLD.

## Timing
- Reset values: `gnt_o`, `rvalid_o`, `err_o`, `sram_oe_o`, `sram_we_o`, `protocol_err_o` = 0; `rdata_o` = 0; `sram_be_o` = 0.
- Read latency is 1 cycle (grant at T, `rvalid_o` at T+1). Back-to-back reads give one grant per cycle.
- Write: grant at T, response at T+1, next grant no earlier than T+2. Write throughput is 1 per 2 cycles.
- Read immediately after a write: granted at T+2. It sees the written data because the commit happened at the end of T+1.
- Responses are in grant order with at most one outstanding, so ordering is trivial. `rvalid_o` never asserts without a prior grant.
- `req_i` low in IDLE: no strobes and no state change.

## Structure
- Package `ibex_sram_pkg` holds:
  - state enum `{IDLE, WHOLD}`;
  - `BUS_DW = 32` and `BE_W = 4`;
  - function `in_window(addr, base, aw)`.
- No sub-module. A single module is sufficient, with one `sram` instantiated only in the testbench.

## Test plan
- Reads: preload word 0x10 = `32'hDEADBEEF`; read `addr_i = 32'h40` → `gnt_o` at T; `rvalid_o`=1, `rdata_o`=`32'hDEADBEEF`, `err_o`=0 at T+1.
- Partial write: write `32'h11223344` with `be_i = 4'b0101` to `32'h40` over `32'hDEADBEEF`; read back → `32'hDE22BE44`; `gnt_o`=0 in WHOLD.
- Out of window: `BASE_ADDR = 32'h8000_0000`, request to `32'h0000_0040` → `rvalid_o`=1, `err_o`=1, `rdata_o`=0; `sram_oe_o`/`sram_we_o` never asserted.
- Throughput: 4 consecutive reads → 4 grants in 4 cycles. Then write followed by read → grants at T and T+2; the read returns the new data.
- Reset in WHOLD: write `32'hCAFEF00D` to `32'h80`, assert `RSTn = 0` in the WHOLD cycle → all outputs 0 next cycle; a later read of `32'h80` returns `32'hCAFEF00D`; word 0 is unchanged.
- Handshake check: force `sram_wack_i = 0` during a write with `be_i = 4'hF` → `protocol_err_o` = 1 and stays 1 until reset.

Source files
------------

// File: rtl/ibex_sram_pkg.sv
// Shared types and helpers for the Ibex-to-SRAM bridge.
package ibex_sram_pkg;

  localparam int BUS_DW = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WHOLD = 1'b1
  } state_e;

  // True when addr falls inside the (4 << aw)-byte window that starts at base.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input int aw);
    return (addr >> (aw + 2)) == (base >> (aw + 2));
  endfunction

endpackage

// File: rtl/ibex_sram_bridge.sv
// Ibex req/gnt/rvalid port to split read/write SRAM port bridge with window
// decode, one-cycle write hold and sticky handshake error detection.
module ibex_sram_bridge
  import ibex_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MEM_ADDR_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [BE_W-1:0]           be_i,
  input  logic [31:0]               addr_i,
  input  logic [BUS_DW-1:0]         wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [BUS_DW-1:0]         rdata_o,
  output logic                      err_o,
  output logic [MEM_ADDR_WIDTH-1:0] sram_read_addr_o,
  output logic                      sram_oe_o,
  input  logic [BUS_DW-1:0]         sram_data_out_i,
  input  logic                      sram_data_valid_i,
  output logic [MEM_ADDR_WIDTH-1:0] sram_write_addr_o,
  output logic [BUS_DW-1:0]         sram_data_in_o,
  output logic [BE_W-1:0]           sram_be_o,
  output logic                      sram_we_o,
  input  logic                      sram_wack_i,
  output logic                      protocol_err_o
);

  state_e                    r_state;
  state_e                    w_state_nxt;
  logic                      r_rd_pend;
  logic                      r_err_pend;
  logic                      r_prot_err;
  logic [MEM_ADDR_WIDTH-1:0] r_waddr;
  logic [BUS_DW-1:0]         r_wdata;
  logic [BE_W-1:0]           r_be;

  logic [MEM_ADDR_WIDTH-1:0] w_idx;
  logic                      w_in_win;
  logic                      w_gnt;
  logic                      w_rd_go;
  logic                      w_wr_go;
  logic                      w_err_go;
  logic                      w_hs_bad;

  assign w_idx    = addr_i[MEM_ADDR_WIDTH+1:2];
  assign w_in_win = in_window(addr_i, BASE_ADDR, MEM_ADDR_WIDTH);

  always_comb begin
    w_state_nxt       = r_state;
    w_gnt             = 1'b0;
    w_rd_go           = 1'b0;
    w_wr_go           = 1'b0;
    w_err_go          = 1'b0;
    sram_oe_o         = 1'b0;
    sram_we_o         = 1'b0;
    sram_be_o         = '0;
    sram_read_addr_o  = w_idx;
    sram_write_addr_o = w_idx;
    sram_data_in_o    = wdata_i;
    case (r_state)
      IDLE: begin
        w_gnt = req_i & RSTn;
        if (w_gnt) begin
          if (!w_in_win) begin
            w_err_go = 1'b1;
          end else if (we_i) begin
            sram_we_o   = 1'b1;
            sram_be_o   = be_i;
            w_wr_go     = 1'b1;
            w_state_nxt = WHOLD;
          end else begin
            sram_oe_o = 1'b1;
            w_rd_go   = 1'b1;
          end
        end
      end
      WHOLD: begin
        // The SRAM commits at the end of this cycle, so address/data come from the hold copy.
        sram_write_addr_o = r_waddr;
        sram_data_in_o    = r_wdata;
        w_state_nxt       = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_hs_bad = (r_rd_pend && !sram_data_valid_i) ||
                    ((r_state == WHOLD) && (r_be != '0) && !sram_wack_i);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state    <= IDLE;
      r_rd_pend  <= 1'b0;
      r_err_pend <= 1'b0;
      r_prot_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_pend  <= w_rd_go;
      r_err_pend <= w_err_go;
      if (w_hs_bad) r_prot_err <= 1'b1;
    end
  end

  // Hold registers stay out of reset so a strobed write still lands correctly.
  always_ff @(posedge CLK) begin
    if (w_wr_go) begin
      r_waddr <= w_idx;
      r_wdata <= wdata_i;
      r_be    <= be_i;
    end
  end

  assign gnt_o          = w_gnt;
  assign rvalid_o       = r_rd_pend | r_err_pend | (r_state == WHOLD);
  assign err_o          = r_err_pend;
  assign rdata_o        = r_rd_pend ? sram_data_out_i : '0;
  assign protocol_err_o = r_prot_err;

endmodule
